// File: rtl/json_scalar_encoder_if.sv
// Command/byte-stream bundle for json_scalar_encoder: scalar command in,
// ASCII byte stream out, each with a valid/ready handshake.
interface json_scalar_encoder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_kind;
  logic [WIDTH-1:0] in_value;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;

  modport master (
    output in_valid, in_kind, in_value, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_kind, in_value, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/json_scalar_encoder.sv
// Encodes one JSON scalar (signed integer, true, false, null) as an ASCII
// byte stream; integers go through a serial double-dabble BCD conversion.
module json_scalar_encoder #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  json_scalar_encoder_if.slave  bus,
  output logic                  busy
);
  localparam int NDIG = (WIDTH * 30103 + 99999) / 100000;
  localparam int BW   = NDIG * 4;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int IW   = (NDIG > 8) ? $clog2(NDIG) : 3;

  localparam logic [1:0] K_INT   = 2'd0;
  localparam logic [1:0] K_TRUE  = 2'd1;
  localparam logic [1:0] K_FALSE = 2'd2;

  typedef enum logic [2:0] {IDLE, CONV, EMIT_SIGN, EMIT_DIG, EMIT_LIT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic             neg_q, neg_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [1:0]       kind_q, kind_d;

  logic [BW-1:0]    bcd_adj;
  logic [IW-1:0]    lead;
  logic             lit_last;

  function automatic logic [7:0] lit_byte(input logic [1:0] k, input logic [IW-1:0] i);
    int unsigned n;
    n = int'(i);
    if (k == K_TRUE) begin
      case (n)
        0: return "t";
        1: return "r";
        2: return "u";
        default: return "e";
      endcase
    end else if (k == K_FALSE) begin
      case (n)
        0: return "f";
        1: return "a";
        2: return "l";
        3: return "s";
        default: return "e";
      endcase
    end else begin
      case (n)
        0: return "n";
        1: return "u";
        default: return "l";
      endcase
    end
  endfunction

  // Add-3 correction per digit, and position of the most significant
  // non-zero digit (0 when the value is zero so a single '0' is emitted).
  always_comb begin
    bcd_adj = '0;
    lead    = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3
                                                    : bcd_q[i*4 +: 4];
      if (bcd_q[i*4 +: 4] != 4'd0) lead = IW'(i);
    end
  end

  assign lit_last = (kind_q == K_FALSE) ? (idx_q == IW'(4)) : (idx_q == IW'(3));

  always_comb begin
    state_d       = state_q;
    mag_d         = mag_q;
    neg_d         = neg_q;
    bcd_d         = bcd_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    kind_d        = kind_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          kind_d = bus.in_kind;
          idx_d  = '0;
          cnt_d  = '0;
          bcd_d  = '0;
          if (bus.in_kind == K_INT) begin
            neg_d   = bus.in_value[WIDTH-1];
            mag_d   = bus.in_value[WIDTH-1] ? (~bus.in_value + 1'b1) : bus.in_value;
            state_d = CONV;
          end else begin
            state_d = EMIT_LIT;
          end
        end
      end
      // WIDTH shift cycles, then one cycle to latch the leading-digit index.
      CONV: begin
        if (cnt_q == CW'(WIDTH)) begin
          idx_d   = lead;
          state_d = neg_q ? EMIT_SIGN : EMIT_DIG;
        end else begin
          bcd_d = {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
          mag_d = {mag_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
        end
      end
      EMIT_SIGN: begin
        bus.out_valid = 1'b1;
        bus.out_data  = 8'h2D;
        if (bus.out_ready) state_d = EMIT_DIG;
      end
      EMIT_DIG: begin
        bus.out_valid = 1'b1;
        bus.out_data  = 8'h30 + {4'h0, bcd_q[{idx_q, 2'b00} +: 4]};
        bus.out_last  = (idx_q == '0);
        if (bus.out_ready) begin
          if (idx_q == '0) state_d = IDLE;
          else             idx_d   = idx_q - 1'b1;
        end
      end
      EMIT_LIT: begin
        bus.out_valid = 1'b1;
        bus.out_data  = lit_byte(kind_q, idx_q);
        bus.out_last  = lit_last;
        if (bus.out_ready) begin
          if (lit_last) state_d = IDLE;
          else          idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      kind_q  <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      kind_q  <= kind_d;
    end
  end

  assign busy = (state_q != IDLE);
endmodule
